// File: rtl/eth_pkg.sv
// Shared Ethernet TX definitions: arbiter state encoding and frame timing constants.
package eth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_GAP   = 2'd3
  } arb_state_t;

  localparam int ETH_MAX_FRAME = 1514;
  // 12 byte-times at 4 clk_mac cycles per byte on RMII
  localparam int ETH_IFG_MAC_CYCLES = 48;
  localparam int BYTE_CNT_W = 14;

  function automatic logic [BYTE_CNT_W-1:0] sat_inc(input logic [BYTE_CNT_W-1:0] v);
    return (&v) ? v : v + BYTE_CNT_W'(1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin select: first set req bit at or after ptr, wrapping mod N.
module rr_pick #(
  parameter int N     = 2,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             any
);

  function automatic int wrap(input int v);
    return (v >= N) ? v - N : v;
  endfunction

  // Scan from farthest to nearest so the closest candidate to ptr wins.
  always_comb begin
    gnt_idx = '0;
    any     = |req;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[wrap(int'(ptr) + k)]) gnt_idx = PTR_W'(wrap(int'(ptr) + k));
    end
  end

endmodule

// File: rtl/mac_tx_arbiter.sv
// Frame-granular round-robin arbiter onto the MAC TX byte stream, with IFG
// enforcement and oversize truncation (excess bytes drained, not forwarded).
module mac_tx_arbiter
  import eth_pkg::*;
#(
  parameter  int N          = 2,
  parameter  int IFG_CYCLES = ETH_IFG_MAC_CYCLES,
  parameter  int MAX_BYTES  = ETH_MAX_FRAME,
  localparam int PTR_W      = $clog2(N)
) (
  input  logic             clk_mac,
  input  logic             rst,
  input  logic [N-1:0]     req_valid,
  input  logic [8*N-1:0]   req_data,
  input  logic [N-1:0]     req_last,
  output logic [N-1:0]     req_ready,
  output logic             mac_valid,
  output logic [7:0]       mac_data,
  output logic             mac_last,
  input  logic             mac_ready,
  output logic [PTR_W-1:0] grant_id,
  output logic             busy,
  output logic             oversize_err
);

  arb_state_t              r_state, w_state_nxt;
  logic [PTR_W-1:0]        r_rr_ptr, r_grant, w_pick, w_ptr_nxt;
  logic [BYTE_CNT_W-1:0]   r_byte_cnt;
  logic [15:0]             r_gap_cnt;
  logic                    r_oversize;
  logic                    w_any, w_sel_valid, w_sel_last, w_at_max;
  logic                    w_hs, w_trunc, w_frame_done;
  logic [7:0]              w_sel_data;
  logic [N-1:0]            w_gnt_oh;

  rr_pick #(.N(N), .PTR_W(PTR_W)) u_pick (
    .req     (req_valid),
    .ptr     (r_rr_ptr),
    .gnt_idx (w_pick),
    .any     (w_any)
  );

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    w_gnt_oh    = '0;
    for (int i = 0; i < N; i++) begin
      if (r_grant == PTR_W'(i)) begin
        w_sel_valid = req_valid[i];
        w_sel_last  = req_last[i];
        w_sel_data  = req_data[8*i +: 8];
        w_gnt_oh[i] = 1'b1;
      end
    end
  end

  // Explicit wrap keeps non-power-of-2 N from reaching an unused index.
  assign w_ptr_nxt = (r_grant == PTR_W'(N - 1)) ? '0 : r_grant + PTR_W'(1);
  assign w_at_max  = (r_byte_cnt == BYTE_CNT_W'(MAX_BYTES - 1));

  always_comb begin
    w_state_nxt  = r_state;
    w_hs         = 1'b0;
    w_trunc      = 1'b0;
    w_frame_done = 1'b0;
    mac_valid    = 1'b0;
    mac_data     = '0;
    mac_last     = 1'b0;
    req_ready    = '0;
    case (r_state)
      ST_IDLE: if (w_any) w_state_nxt = ST_PASS;
      ST_PASS: begin
        mac_valid = w_sel_valid;
        mac_data  = w_sel_data;
        mac_last  = w_sel_last || w_at_max;
        req_ready = w_gnt_oh & {N{mac_ready}};
        w_hs      = w_sel_valid && mac_ready;
        // A real last on the final allowed byte is a clean exit, not a truncation.
        if (w_hs && w_sel_last)  w_frame_done = 1'b1;
        else if (w_hs && w_at_max) begin
          w_trunc     = 1'b1;
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        req_ready = w_gnt_oh;
        if (w_sel_valid && w_sel_last) w_frame_done = 1'b1;
      end
      ST_GAP:  if (r_gap_cnt == '0) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_frame_done) w_state_nxt = (IFG_CYCLES == 0) ? ST_IDLE : ST_GAP;
  end

  always_ff @(posedge clk_mac or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_mac or posedge rst) begin
    if (rst) begin
      r_rr_ptr   <= '0;
      r_grant    <= '0;
      r_byte_cnt <= '0;
      r_gap_cnt  <= '0;
      r_oversize <= 1'b0;
    end else begin
      r_oversize <= w_trunc;
      if (r_state == ST_IDLE && w_any) begin
        r_grant    <= w_pick;
        r_byte_cnt <= '0;
      end
      if (w_hs) r_byte_cnt <= sat_inc(r_byte_cnt);
      if (w_frame_done || w_trunc) r_rr_ptr <= w_ptr_nxt;
      if (w_frame_done)
        r_gap_cnt <= (IFG_CYCLES > 0) ? 16'(IFG_CYCLES - 1) : '0;
      else if (r_state == ST_GAP && r_gap_cnt != '0)
        r_gap_cnt <= r_gap_cnt - 16'd1;
    end
  end

  assign grant_id     = r_grant;
  assign busy         = (r_state != ST_IDLE);
  assign oversize_err = r_oversize;

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Directed bench: DUT A (N=2, IFG 48, MAX 1514) and DUT B (N=3, IFG 0, MAX 8).
module tb_mac_tx_arbiter;

  logic clk_mac = 1'b0;
  logic rst, mac_ready;
  always #5 clk_mac = ~clk_mac;

  logic [1:0]  a_rv, a_rl, a_rr;
  logic [15:0] a_rd;
  logic        a_mv, a_ml, a_gid, a_busy, a_oe;
  logic [7:0]  a_md;
  logic [2:0]  b_rv, b_rl, b_rr;
  logic [23:0] b_rd;
  logic        b_mv, b_ml, b_busy, b_oe;
  logic [1:0]  b_gid;
  logic [7:0]  b_md;

  mac_tx_arbiter dut_a (
    .clk_mac(clk_mac), .rst(rst), .req_valid(a_rv), .req_data(a_rd), .req_last(a_rl),
    .req_ready(a_rr), .mac_valid(a_mv), .mac_data(a_md), .mac_last(a_ml),
    .mac_ready(mac_ready), .grant_id(a_gid), .busy(a_busy), .oversize_err(a_oe));

  mac_tx_arbiter #(.N(3), .IFG_CYCLES(0), .MAX_BYTES(8)) dut_b (
    .clk_mac(clk_mac), .rst(rst), .req_valid(b_rv), .req_data(b_rd), .req_last(b_rl),
    .req_ready(b_rr), .mac_valid(b_mv), .mac_data(b_md), .mac_last(b_ml),
    .mac_ready(mac_ready), .grant_id(b_gid), .busy(b_busy), .oversize_err(b_oe));

  int dsel = 0;
  logic       mv, ml, busy_o, oe;
  logic [7:0] md;
  logic [2:0] rr;
  logic [1:0] gid;

  always_comb begin
    if (dsel == 0) begin
      mv = a_mv; ml = a_ml; md = a_md; busy_o = a_busy; oe = a_oe;
      rr = {1'b0, a_rr}; gid = {1'b0, a_gid};
    end else begin
      mv = b_mv; ml = b_ml; md = b_md; busy_o = b_busy; oe = b_oe;
      rr = b_rr; gid = b_gid;
    end
  end

  int errors = 0, checks = 0;
  int nf, na, cyc, nov, g;
  logic [7:0] fr [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] bv(input int s, input int i);
    return fr[i] + 8'(s * 16);
  endfunction

  task automatic set_src(input int s, input logic v, input logic [7:0] d, input logic l);
    if (dsel == 0) begin a_rv[s] = v; a_rd[8*s +: 8] = d; a_rl[s] = l; end
    else           begin b_rv[s] = v; b_rd[8*s +: 8] = d; b_rl[s] = l; end
  endtask

  // Source s offers len bytes (last on the final one) until accepted or stop_at reached.
  task automatic frame(input int s, input int len, input bit tog, input int maxb,
                       input int stop_at, output int fwd, output int acc,
                       output int ncyc, output int npulse);
    int idx;
    bit r;
    idx = 0; r = 1'b1; fwd = 0; acc = 0; ncyc = 0; npulse = 0;
    while (idx < len && idx != stop_at && ncyc < 300) begin
      @(negedge clk_mac);
      mac_ready = tog ? r : 1'b1;
      set_src(s, 1'b1, bv(s, idx), idx == len - 1);
      #1;
      npulse += int'(oe);
      if (mv) begin
        chk("data", md, bv(s, fwd));
        chk("last", ml, (fwd == len - 1) || (fwd == maxb - 1));
        chk("rdy_mirror", rr[s], mac_ready);
        if (mac_ready) fwd++;
      end
      if (rr[s]) begin idx++; acc++; end
      ncyc++;
      r = ~r;
    end
    chk("frame_done", (idx == len) || (idx == stop_at), 1);
  endtask

  task automatic finish_src(input int s);
    @(posedge clk_mac); #1;
    set_src(s, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic gap_wait(output int len);
    int bad;
    bad = 0; len = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk_mac); #1;
      if (!busy_o) break;
      if (mv || rr != 3'b000) bad++;
      len++;
    end
    chk("gap_quiet", bad, 0);
  endtask

  initial begin
    fr = '{8'heb, 8'heb, 8'h00, 8'h00, 8'h00, 8'hff, 8'hff, 8'hff,
           8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04};
    rst = 1'b1; mac_ready = 1'b0;
    a_rv = '0; a_rl = '0; a_rd = '0; b_rv = '0; b_rl = '0; b_rd = '0;
    #12;
    dsel = 0; #1 chk("rst_a", {mv, ml, md, rr, oe, busy_o, gid}, 0);
    dsel = 1; #1 chk("rst_b", {mv, ml, md, rr, oe, busy_o, gid}, 0);
    @(negedge clk_mac); rst = 1'b0; mac_ready = 1'b1;
    dsel = 0;

    // single source, 14 bytes, then IFG
    frame(0, 14, 1'b0, 1514, -1, nf, na, cyc, nov);
    chk("t1_bytes", nf, 14);
    chk("t1_gid", gid, 0);
    finish_src(0);
    gap_wait(g);
    chk("t1_gap", g, 48);

    // contention: both valid on the first cycle after reset
    @(negedge clk_mac); rst = 1'b1;
    set_src(0, 1'b1, bv(0, 0), 1'b0);
    set_src(1, 1'b1, bv(1, 0), 1'b0);
    @(negedge clk_mac); rst = 1'b0;
    frame(0, 4, 1'b0, 1514, -1, nf, na, cyc, nov);
    chk("c1_bytes", nf, 4);
    chk("c1_gid", gid, 0);
    @(posedge clk_mac); #1;
    set_src(0, 1'b1, bv(0, 0), 1'b0);
    gap_wait(g);
    chk("c1_gap", g, 48);
    frame(1, 4, 1'b0, 1514, -1, nf, na, cyc, nov);
    chk("c2_bytes", nf, 4);
    chk("c2_gid", gid, 1);
    finish_src(1);
    gap_wait(g);
    chk("c2_gap", g, 48);
    frame(0, 4, 1'b0, 1514, -1, nf, na, cyc, nov);
    chk("c3_gid", gid, 0);
    finish_src(0);
    gap_wait(g);

    // backpressure: mac_ready toggles during a 6-byte frame
    frame(0, 6, 1'b1, 1514, -1, nf, na, cyc, nov);
    chk("bp_fwd", nf, 6);
    chk("bp_acc", na, 6);
    finish_src(0);
    gap_wait(g);

    // reset mid-frame after byte 3 from requester 1
    frame(1, 6, 1'b0, 1514, 3, nf, na, cyc, nov);
    @(posedge clk_mac); #2;
    rst = 1'b1; #1;
    chk("rm_out", {mv, ml, md, rr, oe}, 0);
    chk("rm_busy", busy_o, 0);
    chk("rm_gid", gid, 0);
    set_src(0, 1'b1, bv(0, 0), 1'b0);
    set_src(1, 1'b1, bv(1, 0), 1'b0);
    @(negedge clk_mac); rst = 1'b0;
    frame(0, 4, 1'b0, 1514, -1, nf, na, cyc, nov);
    chk("rm_bytes", nf, 4);
    chk("rm_gid2", gid, 0);
    finish_src(0);
    set_src(1, 1'b0, 8'h00, 1'b0);

    // DUT B: oversize truncation, requester 1 sends 12 bytes with MAX 8
    dsel = 1;
    frame(1, 12, 1'b0, 8, -1, nf, na, cyc, nov);
    chk("ov_fwd", nf, 8);
    chk("ov_acc", na, 12);
    chk("ov_pulse", nov, 1);
    chk("ov_gid", gid, 1);
    finish_src(1);
    @(negedge clk_mac); #1;
    chk("ov_idle", busy_o, 0);

    // exactly MAX bytes with last on byte 8: no error
    frame(1, 8, 1'b0, 8, -1, nf, na, cyc, nov);
    chk("bd_fwd", nf, 8);
    chk("bd_pulse", nov, 0);
    finish_src(1);
    @(negedge clk_mac); #1;
    chk("bd_noerr", {oe, busy_o}, 0);

    // IFG 0: back-to-back frames cost only the IDLE bubble
    frame(2, 3, 1'b0, 8, -1, nf, na, cyc, nov);
    chk("b2b_cyc1", cyc, 4);
    frame(2, 3, 1'b0, 8, -1, nf, na, cyc, nov);
    chk("b2b_cyc2", cyc, 4);
    chk("b2b_gid", gid, 2);

    // pointer wraps from requester 2 to 0
    @(posedge clk_mac); #1;
    set_src(2, 1'b1, bv(2, 0), 1'b0);
    set_src(0, 1'b1, bv(0, 0), 1'b0);
    frame(0, 2, 1'b0, 8, -1, nf, na, cyc, nov);
    chk("wrap_gid", gid, 0);
    chk("wrap_fwd", nf, 2);
    finish_src(0);
    set_src(2, 1'b0, 8'h00, 1'b0);
    repeat (2) @(negedge clk_mac);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
